// File: rtl/shift_add_ctrl.sv
// shift_add_ctrl: control FSM for a shift-and-add multiplier.
// It sequences the multiplicand register A, the multiplier shift register B
// and the accumulator P through N add/shift iterations. A Start/Ready/Done
// handshake surrounds each multiply.
//
// Optional build macro SHIFT_ADD_CTRL_SKIP_EN: a zero multiplier bit is
// shifted directly from ADD, so SHF is used only for one bits. The default
// build (macro undefined) always takes exactly 2N+2 cycles from Start to Done.
module shift_add_ctrl #(
   parameter int N  = 8,
   parameter int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          Start,
   input  logic          B0,
   output logic          LdA,
   output logic          LdB,
   output logic          ClrP,
   output logic          LdP,
   output logic          ShiftPB,
   output logic          Ready,
   output logic          Done,
   output logic [CW-1:0] Cnt
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_INIT = 3'd1;
   localparam logic [2:0] S_ADD  = 3'd2;
   localparam logic [2:0] S_SHF  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_bit;

   assign last_bit = (cnt_q == CNT_LAST);

   // Next-state and iteration counter; a stray encoding falls back to IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (Start) state_d = S_INIT;
         end
         S_INIT: begin
            cnt_d   = '0;
            state_d = S_ADD;
         end
         S_ADD: begin
`ifdef SHIFT_ADD_CTRL_SKIP_EN
            // A zero bit needs no add, so the shift happens here directly.
            if (B0) begin
               state_d = S_SHF;
            end else if (last_bit) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = S_ADD;
            end
`else
            state_d = S_SHF;
`endif
         end
         S_SHF: begin
            if (last_bit) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = S_ADD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and counter registers; reset returns to IDLE at once, mid-operation included.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Datapath strobes: all Moore except LdP (and ShiftPB in ADD when skipping).
   always_comb begin
      LdA     = (state_q == S_INIT);
      LdB     = (state_q == S_INIT);
      ClrP    = (state_q == S_INIT);
      LdP     = (state_q == S_ADD) && B0;
`ifdef SHIFT_ADD_CTRL_SKIP_EN
      ShiftPB = (state_q == S_SHF) || ((state_q == S_ADD) && !B0);
`else
      ShiftPB = (state_q == S_SHF);
`endif
      Ready   = (state_q == S_IDLE);
      Done    = (state_q == S_DONE);
   end

   assign Cnt = cnt_q;

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Testbench for shift_add_ctrl. A behavioural A/B/P register model is driven
// by the controller strobes and supplies B0. Results are compared with a*b,
// popcount(b) and the expected latency.
module tb_shift_add_ctrl;
   localparam int N  = 8;
   localparam int CW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst;
   logic          Start;
   logic          B0;
   logic          LdA, LdB, ClrP, LdP, ShiftPB, Ready, Done;
   logic [CW-1:0] Cnt;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] a_in, b_in;
   logic [N-1:0] a_q, b_q;
   logic [N:0]   p_q;

   shift_add_ctrl #(.N(N), .CW(CW)) dut (
      .clk(clk), .rst(rst), .Start(Start), .B0(B0),
      .LdA(LdA), .LdB(LdB), .ClrP(ClrP), .LdP(LdP), .ShiftPB(ShiftPB),
      .Ready(Ready), .Done(Done), .Cnt(Cnt)
   );

   always #5 clk = ~clk;

   assign B0 = b_q[0];

   // Datapath register model reacting to the strobes.
   always @(posedge clk) begin
      if (LdA) a_q <= a_in;
      if (LdB) b_q <= b_in;
      if (ClrP) p_q <= '0;
      else if (LdP) p_q <= p_q + {1'b0, a_q};
      if (ShiftPB) begin
         p_q <= {1'b0, p_q[N:1]};
         b_q <= {p_q[0], b_q[N-1:1]};
      end
   end

   // Cycles from the Start-sampling edge to the Done cycle (INIT is cycle 1).
   function automatic int exp_lat(input logic [N-1:0] b);
`ifdef SHIFT_ADD_CTRL_SKIP_EN
      return 2 + N + $countones(b);
`else
      return 2 * N + 2;
`endif
   endfunction

   // One multiply; gathers latency, product, strobe counts and invariant violations.
   task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b, input bit noise,
                          input int pulse_j, output int lat, output logic [2*N-1:0] prod,
                          output int nld, output int nsh, output int bad,
                          output logic rdy_after, output logic done_after);
      @(negedge clk);
      a_in = a; b_in = b; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      lat = -1; nld = 0; nsh = 0; bad = 0; prod = '0;
      for (int j = 1; j <= 4 * N + 8; j++) begin
         if (j > 1) @(negedge clk);
         if (LdP) nld++;
         if (ShiftPB) nsh++;
         if (LdP && ShiftPB) bad++;
         if (int'(Cnt) >= N) bad++;
         if (j == 1) begin
            if (!(LdA && LdB && ClrP)) bad++;
         end else if (LdA || LdB || ClrP) bad++;
         if (Ready) bad++;
         if (Done) begin
            lat = j;
            prod = {p_q[N-1:0], b_q};
            break;
         end
         Start = noise ? 1'($urandom_range(0, 1)) : (j == pulse_j);
      end
      Start = 1'b0;
      @(negedge clk);
      rdy_after = Ready;
      done_after = Done;
   endtask

   task automatic test_reset();
      rst = 1'b1; Start = 1'b0; a_in = '0; b_in = '0;
      #2 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({LdA, LdB, ClrP, LdP, ShiftPB, Ready, Done} !== 7'b0000010) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0000010",
                  {LdA, LdB, ClrP, LdP, ShiftPB, Ready, Done});
      end
      checks++;
      if (Cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", Cnt); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (Ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", Ready); end
   endtask

   task automatic test_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit noise, input int pulse_j);
      int lat, nld, nsh, bad;
      logic [2*N-1:0] prod, want;
      logic ra, da;
      want = (2*N)'(a) * (2*N)'(b);
      do_mult(a, b, noise, pulse_j, lat, prod, nld, nsh, bad, ra, da);
      checks++;
      if (lat != exp_lat(b)) begin errors++; $display("FAIL %s_latency a=%h b=%h got %0d want %0d", name, a, b, lat, exp_lat(b)); end
      checks++;
      if (prod !== want) begin errors++; $display("FAIL %s_product a=%h b=%h got %h want %h", name, a, b, prod, want); end
      checks++;
      if (nld != $countones(b)) begin errors++; $display("FAIL %s_ldp_count b=%h got %0d want %0d", name, b, nld, $countones(b)); end
      checks++;
      if (nsh != N) begin errors++; $display("FAIL %s_shift_count got %0d want %0d", name, nsh, N); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s_invariants violations %0d want 0", name, bad); end
      checks++;
      if ({ra, da} !== 2'b10) begin errors++; $display("FAIL %s_after_done ready,done got %b want 10", name, {ra, da}); end
   endtask

   task automatic test_basic();
      test_op("basic", 8'd13, 8'd11, 1'b0, 0);
   endtask

   task automatic test_boundary();
      test_op("ff_ff", 8'hFF, 8'hFF, 1'b0, 0);
      test_op("00_a5", 8'h00, 8'hA5, 1'b0, 0);
      test_op("a5_00", 8'hA5, 8'h00, 1'b0, 0);
      test_op("80_01", 8'h80, 8'h01, 1'b0, 0);
   endtask

   task automatic test_start_busy();
      // Extra Start pulse during SHF of iteration 2 must not restart.
      test_op("busy_pulse", 8'd200, 8'hFF, 1'b0, 7);
      @(negedge clk);
      checks++;
      if (Ready !== 1'b1 || LdA !== 1'b0) begin
         errors++; $display("FAIL busy_no_restart ready=%b lda=%b want 1 0", Ready, LdA);
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] a1, b1, a2, b2;
      logic [2*N-1:0] p1, p2;
      int d1, d2, init2;
      logic gap_rdy;
      a1 = N'($urandom); b1 = N'($urandom); a2 = N'($urandom); b2 = N'($urandom);
      d1 = 0; d2 = 0; init2 = 0; gap_rdy = 1'b0; p1 = '0; p2 = '0;
      @(negedge clk);
      a_in = a1; b_in = b1; Start = 1'b1;
      for (int j = 1; j <= 8 * N + 16; j++) begin
         @(negedge clk);
         if (j == 2) begin a_in = a2; b_in = b2; end
         if (LdA && j > 1 && init2 == 0) init2 = j;
         if (d1 != 0 && j == d1 + 1) gap_rdy = Ready;
         if (Done) begin
            if (d1 == 0) begin d1 = j; p1 = {p_q[N-1:0], b_q}; end
            else begin d2 = j; p2 = {p_q[N-1:0], b_q}; break; end
         end
      end
      Start = 1'b0;
      checks++;
      if (d1 != exp_lat(b1)) begin errors++; $display("FAIL b2b_done1 got %0d want %0d", d1, exp_lat(b1)); end
      checks++;
      if (gap_rdy !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap ready got %b want 1", gap_rdy); end
      checks++;
      if (init2 != exp_lat(b1) + 2) begin errors++; $display("FAIL b2b_init2 got %0d want %0d", init2, exp_lat(b1) + 2); end
      checks++;
      if (d2 != exp_lat(b1) + 1 + exp_lat(b2)) begin errors++; $display("FAIL b2b_done2 got %0d want %0d", d2, exp_lat(b1) + 1 + exp_lat(b2)); end
      checks++;
      if (p1 !== (2*N)'(a1) * (2*N)'(b1)) begin errors++; $display("FAIL b2b_prod1 got %h want %h", p1, (2*N)'(a1) * (2*N)'(b1)); end
      checks++;
      if (p2 !== (2*N)'(a2) * (2*N)'(b2)) begin errors++; $display("FAIL b2b_prod2 got %h want %h", p2, (2*N)'(a2) * (2*N)'(b2)); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int seen_done, seen_busy;
      @(negedge clk);
      a_in = N'($urandom); b_in = 8'hFF; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (7) @(negedge clk);
      // Now in ADD of iteration 3 with B0=1.
      checks++;
      if (Cnt !== 3'd3 || LdP !== 1'b1) begin
         errors++; $display("FAIL mid_pre_reset cnt=%0d ldp=%b want 3 1", Cnt, LdP);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({LdA, LdB, ClrP, LdP, ShiftPB, Ready, Done} !== 7'b0000010) begin
         errors++; $display("FAIL mid_reset_outputs got %b want 0000010",
                            {LdA, LdB, ClrP, LdP, ShiftPB, Ready, Done});
      end
      checks++;
      if (Cnt !== '0) begin errors++; $display("FAIL mid_reset_cnt got %0d want 0", Cnt); end
      @(negedge clk);
      rst = 1'b1;
      seen_done = 0; seen_busy = 0;
      for (int j = 0; j < 2 * N + 6; j++) begin
         @(negedge clk);
         if (Done) seen_done++;
         if (!Ready) seen_busy++;
      end
      checks++;
      if (seen_done != 0 || seen_busy != 0) begin
         errors++; $display("FAIL mid_no_done done_cycles=%0d busy_cycles=%0d want 0 0", seen_done, seen_busy);
      end
      test_op("after_reset", N'($urandom), N'($urandom), 1'b0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 1000; i++)
         test_op("rand", N'($urandom), N'($urandom), 1'b1, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_start_busy();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
